// File: rtl/output_queue_ctrl.sv
// Output-port FIFO: device-bus writes to OUT_ADDR are queued and drained on a valid/ready channel.
// Optional OUTPUT_QUEUE_TIMESTAMP_EN adds a free-running cycle stamp per entry and an out_timestamp port.
module output_queue_ctrl #(
   parameter int          NUM_CORES   = 16,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [9:0]  OUT_ADDR    = 10'h3ff,
   parameter logic [9:0]  STATUS_ADDR = 10'h3fc,
   localparam int         CW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [CW-1:0] device_core_id,
   input  logic          device_write_en,
   input  logic          device_read_en,
   input  logic [9:0]    device_addr,
   input  logic [15:0]   device_data_out,
   output logic [15:0]   rd_data,
   output logic          rd_hit,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_core_id,
`ifdef OUTPUT_QUEUE_TIMESTAMP_EN
   output logic [15:0]   out_timestamp,
`endif
   output logic [15:0]   out_data
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);
`ifdef OUTPUT_QUEUE_TIMESTAMP_EN
   localparam int EW = 16 + CW + 16;
`else
   localparam int EW = CW + 16;
`endif

   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNTW-1:0] count_reg;
   logic            overflow_reg;
   logic [15:0]     rd_data_reg;
   logic            rd_hit_reg;

   logic            push, pop, full, push_acc, ovf_set, ovf_clr, status_rd;
   logic [EW-1:0]   entry_w, head_w;
   logic [7:0]      free_w;

   assign push      = device_write_en && (device_addr == OUT_ADDR);
   assign ovf_clr   = device_write_en && (device_addr == STATUS_ADDR);
   assign status_rd = device_read_en && (device_addr == STATUS_ADDR);
   assign full      = (count_reg == DEPTH_C);
   assign pop       = out_valid && out_ready;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push_acc  = push && (!full || pop);
   assign ovf_set   = push && full && !pop;
   assign free_w    = 8'(DEPTH_C - count_reg);

`ifdef OUTPUT_QUEUE_TIMESTAMP_EN
   logic [15:0] ts_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts_reg <= 16'd0;
      else          ts_reg <= ts_reg + 16'd1;
   end

   assign entry_w       = {ts_reg, device_core_id, device_data_out};
   assign out_timestamp = out_valid ? head_w[EW-1 -: 16] : 16'd0;
`else
   assign entry_w = {device_core_id, device_data_out};
`endif

   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr_reg] <= entry_w;
   end

   assign head_w = mem[rd_ptr_reg];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         rd_data_reg  <= 16'd0;
         rd_hit_reg   <= 1'b0;
      end else begin
         if (push_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)      rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push_acc && !pop)      count_reg <= count_reg + CNTW'(1);
         else if (pop && !push_acc) count_reg <= count_reg - CNTW'(1);
         // Set has priority over clear.
         if (ovf_set)      overflow_reg <= 1'b1;
         else if (ovf_clr) overflow_reg <= 1'b0;
         rd_hit_reg <= status_rd;
         if (status_rd) rd_data_reg <= {overflow_reg, 7'b0, free_w};
      end
   end

   assign out_valid   = (count_reg != '0);
   // Gate the unreset storage so idle outputs read as zero.
   assign out_core_id = out_valid ? head_w[16 +: CW] : '0;
   assign out_data    = out_valid ? head_w[15:0]    : 16'd0;
   assign rd_data     = rd_data_reg;
   assign rd_hit      = rd_hit_reg;

endmodule

// File: tb/tb_output_queue_ctrl.sv
// Directed self-checking bench for output_queue_ctrl (FIFO_DEPTH=8, NUM_CORES=16).
module tb_output_queue_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [CW-1:0] device_core_id = '0;
   logic          device_write_en = 1'b0;
   logic          device_read_en = 1'b0;
   logic [9:0]    device_addr = 10'h0;
   logic [15:0]   device_data_out = 16'h0;
   logic [15:0]   rd_data;
   logic          rd_hit;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_core_id;
   logic [15:0]   out_data;
`ifdef OUTPUT_QUEUE_TIMESTAMP_EN
   logic [15:0]   out_timestamp;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   output_queue_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .device_core_id (device_core_id),
      .device_write_en(device_write_en),
      .device_read_en (device_read_en),
      .device_addr    (device_addr),
      .device_data_out(device_data_out),
      .rd_data        (rd_data),
      .rd_hit         (rd_hit),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_core_id    (out_core_id),
`ifdef OUTPUT_QUEUE_TIMESTAMP_EN
      .out_timestamp  (out_timestamp),
`endif
      .out_data       (out_data)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [CW-1:0] id, input logic [15:0] d);
      device_write_en = 1'b1;
      device_addr     = 10'h3ff;
      device_core_id  = id;
      device_data_out = d;
      cycle();
      device_write_en = 1'b0;
   endtask

   task automatic do_status(output logic [15:0] d, output logic hit);
      device_read_en = 1'b1;
      device_addr    = 10'h3fc;
      cycle();
      device_read_en = 1'b0;
      d   = rd_data;
      hit = rd_hit;
      $display("status read: rd_hit=%0b rd_data=%04h", hit, d);
   endtask

   task automatic test_reset();
      logic [15:0] d;
      logic        h;
      reset_n = 1'b0;
      repeat (2) cycle();
      reset_n = 1'b1;
      cycle();
      n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      n_cmp++; if (rd_hit !== 1'b0)      begin n_bad++; $display("FAIL reset_rd_hit got=%0b exp=0", rd_hit); end
      n_cmp++; if (rd_data !== 16'h0)    begin n_bad++; $display("FAIL reset_rd_data got=%04h exp=0000", rd_data); end
      n_cmp++; if (out_data !== 16'h0)   begin n_bad++; $display("FAIL reset_out_data got=%04h exp=0000", out_data); end
      n_cmp++; if (out_core_id !== 4'h0) begin n_bad++; $display("FAIL reset_out_core_id got=%0h exp=0", out_core_id); end
      do_status(d, h);
      n_cmp++; if (h !== 1'b1)     begin n_bad++; $display("FAIL reset_status_hit got=%0b exp=1", h); end
      n_cmp++; if (d !== 16'h0008) begin n_bad++; $display("FAIL reset_status got=%04h exp=0008", d); end
      cycle();
      n_cmp++; if (rd_hit !== 1'b0)     begin n_bad++; $display("FAIL hold_rd_hit got=%0b exp=0", rd_hit); end
      n_cmp++; if (rd_data !== 16'h0008) begin n_bad++; $display("FAIL hold_rd_data got=%04h exp=0008", rd_data); end
   endtask

   task automatic test_single();
      logic [15:0] d;
      logic        h;
      out_ready = 1'b0;
      do_push(4'd3, 16'h1234);
      $display("push core=3 data=1234");
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_core_id !== 4'd3 || out_data !== 16'h1234) begin
            n_bad++;
            $display("FAIL single_hold[%0d] got v=%0b id=%0h d=%04h exp v=1 id=3 d=1234", i, out_valid, out_core_id, out_data);
         end
         cycle();
      end
      do_status(d, h);
      n_cmp++; if (d !== 16'h0007) begin n_bad++; $display("FAIL single_status got=%04h exp=0007", d); end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop_valid got=%0b exp=0", out_valid); end
   endtask

   task automatic test_overflow();
      logic [15:0] d;
      logic        h;
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) do_push(CW'(i), 16'(i));
      $display("pushed 9 words into depth 8");
      do_status(d, h);
      n_cmp++; if (d !== 16'h8000) begin n_bad++; $display("FAIL ovf_status got=%04h exp=8000", d); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 16'(i) || out_core_id !== CW'(i)) begin
            n_bad++;
            $display("FAIL ovf_drain[%0d] got v=%0b id=%0h d=%04h exp v=1 id=%0h d=%04h", i, out_valid, out_core_id, out_data, i, i);
         end
         $display("drain word %0d: data=%04h", i, out_data);
         cycle();
      end
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained_valid got=%0b exp=0", out_valid); end
      do_status(d, h);
      n_cmp++; if (d !== 16'h8008) begin n_bad++; $display("FAIL ovf_sticky got=%04h exp=8008", d); end
      device_write_en = 1'b1;
      device_addr     = 10'h3fc;
      device_data_out = 16'hbeef;
      cycle();
      device_write_en = 1'b0;
      do_status(d, h);
      n_cmp++; if (d !== 16'h0008) begin n_bad++; $display("FAIL ovf_clear got=%04h exp=0008", d); end
   endtask

   task automatic test_full_push_pop();
      logic [15:0] d;
      logic        h;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) do_push(4'd5, 16'h0100 + 16'(i));
      out_ready       = 1'b1;
      device_write_en = 1'b1;
      device_addr     = 10'h3ff;
      device_core_id  = 4'd9;
      device_data_out = 16'h0200;
      cycle();
      device_write_en = 1'b0;
      out_ready       = 1'b0;
      $display("full push+pop: pushed 0200");
      do_status(d, h);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL fullpp_status got=%04h exp=0000", d); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [15:0] ed;
         logic [3:0]  ei;
         ed = (i < 7) ? 16'h0101 + 16'(i) : 16'h0200;
         ei = (i < 7) ? 4'd5 : 4'd9;
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== ed || out_core_id !== ei) begin
            n_bad++;
            $display("FAIL fullpp_drain[%0d] got v=%0b id=%0h d=%04h exp v=1 id=%0h d=%04h", i, out_valid, out_core_id, out_data, ei, ed);
         end
         cycle();
      end
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fullpp_empty got=%0b exp=0", out_valid); end
   endtask

   task automatic test_wrap();
      logic [19:0] q[$];
      logic [19:0] exp_e;
      logic [15:0] d;
      logic        h;
      int cyc = 0, pushed = 0, got = 0;
      bit do_p;
      while ((pushed < 20 || got < 20) && cyc < 200) begin
         do_p = (pushed < 20) && (cyc % 3 != 2) && (q.size() < 8);
         out_ready       = (cyc % 2 == 1);
         device_write_en = do_p;
         device_addr     = 10'h3ff;
         device_core_id  = CW'(pushed % 16);
         device_data_out = 16'ha000 + 16'(pushed);
         n_cmp++;
         if (out_valid !== (q.size() != 0)) begin
            n_bad++;
            $display("FAIL wrap_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, q.size() != 0);
         end
         if (out_valid && out_ready && q.size() != 0) begin
            exp_e = q.pop_front();
            n_cmp++;
            if ({out_core_id, out_data} !== exp_e) begin
               n_bad++;
               $display("FAIL wrap_data[%0d] got id=%0h d=%04h exp id=%0h d=%04h", got, out_core_id, out_data, exp_e[19:16], exp_e[15:0]);
            end
            $display("wrap pop %0d: id=%0h data=%04h", got, out_core_id, out_data);
            got++;
         end
         if (do_p) begin
            q.push_back({device_core_id, device_data_out});
            pushed++;
         end
         cycle();
         cyc++;
      end
      device_write_en = 1'b0;
      out_ready       = 1'b0;
      n_cmp++; if (got != 20) begin n_bad++; $display("FAIL wrap_count got=%0d exp=20", got); end
      do_status(d, h);
      n_cmp++; if (d !== 16'h0008) begin n_bad++; $display("FAIL wrap_status got=%04h exp=0008", d); end
   endtask

   task automatic test_async_reset();
      logic [15:0] d;
      logic        h;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) do_push(4'd7, 16'h0c00 + 16'(i));
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid got=%0b exp=1", out_valid); end
      #2;
      reset_n = 1'b0;
      #1;
      $display("async reset asserted mid-cycle");
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid got=%0b exp=0", out_valid); end
      n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL areset_data got=%04h exp=0000", out_data); end
      cycle();
      reset_n = 1'b1;
      cycle();
      do_status(d, h);
      n_cmp++; if (h !== 1'b1 || d !== 16'h0008) begin n_bad++; $display("FAIL areset_status got hit=%0b d=%04h exp hit=1 d=0008", h, d); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
